// File: rtl/miriscv_mem_initiator.sv
// miriscv_mem_initiator
//   Requesting end of the MIRISCV data-memory bus. Commands come in on a
//   valid/ready port. Each accepted command is driven onto the bus for one
//   cycle. Responses are returned in order through a small buffer.
//
//   Handshake rule (cmd_* and rsp_*): a transfer happens in any cycle where
//   valid and ready are both 1 at the rising edge. Once valid is raised, the
//   producer keeps valid and its payload stable until the transfer happens.
//   cmd_ready_o depends only on internal state, never on cmd_valid_i.
//
//   Ports
//     clk_i, arstn_i      clock, synchronous active-low reset
//     cmd_*               command input (we/addr/wdata/be)
//     data_*              memory bus: req/we/be/addr/wdata out, rvalid/rdata in
//     rsp_*               response output (rdata, we tag)
//     idle_o              nothing in flight and response buffer empty
//     proto_err_o         sticky: rvalid arrived with nothing outstanding
//     timeout_o           sticky watchdog flag
//
//   Optional feature macro: MIRISCV_MEM_INIT_TIMEOUT_EN
//     Adds a watchdog that sets timeout_o after TIMEOUT_CYCLES cycles with
//     requests outstanding and no rvalid. After that, new commands are blocked.
//     Without the macro, timeout_o is tied to 0.
module miriscv_mem_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_we_o,
  output logic        idle_o,
  output logic        proto_err_o,
  output logic        timeout_o
);

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int RCW = $clog2(RSP_DEPTH + 1);
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic            req_q, req_d, we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [OCW-1:0]  out_cnt_q, out_cnt_d;
  logic [TPW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic            tag_mem_q [MAX_OUTSTANDING];
  logic            tag_mem_d [MAX_OUTSTANDING];
  logic [RCW-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic [RPW-1:0]  rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [31:0]     rsp_data_q [RSP_DEPTH];
  logic [31:0]     rsp_data_d [RSP_DEPTH];
  logic            rsp_tag_q  [RSP_DEPTH];
  logic            rsp_tag_d  [RSP_DEPTH];
  logic            proto_err_q, proto_err_d;

  logic cmd_fire, rv_accept, rv_stray, rsp_pop, credit_ok;

  // The outstanding count goes up at the fire edge. So it already includes
  // the request being driven in the req cycle. Credit therefore never
  // double-books a slot.
  always_comb begin
    credit_ok   = (32'(out_cnt_q) < 32'(MAX_OUTSTANDING)) &&
                  ((32'(out_cnt_q) + 32'(rsp_cnt_q)) < 32'(RSP_DEPTH));
    cmd_ready_o = arstn_i && credit_ok && !timeout_o;
    cmd_fire    = cmd_valid_i && cmd_ready_o;
    rv_accept   = data_rvalid_i && (out_cnt_q != '0);
    rv_stray    = data_rvalid_i && (out_cnt_q == '0);
    rsp_valid_o = (rsp_cnt_q != '0);
    rsp_pop     = rsp_valid_o && rsp_ready_i;
  end

  always_comb begin
    req_d       = cmd_fire;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_cnt_d   = out_cnt_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    tag_mem_d   = tag_mem_q;
    rsp_cnt_d   = rsp_cnt_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    proto_err_d = proto_err_q || rv_stray;

    if (cmd_fire) begin
      we_d    = cmd_we_i;
      be_d    = cmd_be_i;
      addr_d  = cmd_addr_i;
      wdata_d = cmd_wdata_i;
      tag_mem_d[tag_wr_q] = cmd_we_i;
      tag_wr_d = (tag_wr_q == TPW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + TPW'(1);
    end

    // Accepted rvalid: retire the oldest tag and queue its response.
    // Write responses carry zero data.
    if (rv_accept) begin
      tag_rd_d = (tag_rd_q == TPW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + TPW'(1);
      rsp_data_d[rsp_wr_q] = tag_mem_q[tag_rd_q] ? 32'h0 : data_rdata_i;
      rsp_tag_d[rsp_wr_q]  = tag_mem_q[tag_rd_q];
      rsp_wr_d = (rsp_wr_q == RPW'(RSP_DEPTH - 1)) ? '0 : rsp_wr_q + RPW'(1);
    end

    if (rsp_pop) begin
      rsp_rd_d = (rsp_rd_q == RPW'(RSP_DEPTH - 1)) ? '0 : rsp_rd_q + RPW'(1);
    end

    case ({cmd_fire, rv_accept})
      2'b10:   out_cnt_d = out_cnt_q + OCW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OCW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    case ({rv_accept, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + RCW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - RCW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_cnt_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      rsp_cnt_q   <= '0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_data_q[i] <= '0;
        rsp_tag_q[i]  <= 1'b0;
      end
    end else begin
      req_q       <= req_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_cnt_q   <= out_cnt_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      tag_mem_q   <= tag_mem_d;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef MIRISCV_MEM_INIT_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCW-1:0] wd_cnt_q, wd_cnt_d;
  logic           timeout_q, timeout_d;

  // The count saturates at the limit. The flag is raised in the same edge
  // that the count reaches the limit.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((out_cnt_q == '0) || rv_accept) begin
      wd_cnt_d = '0;
    end else if (32'(wd_cnt_q) < 32'(TIMEOUT_CYCLES)) begin
      wd_cnt_d = wd_cnt_q + WCW'(1);
    end
    timeout_d = timeout_q || (32'(wd_cnt_d) >= 32'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign rsp_rdata_o  = rsp_data_q[rsp_rd_q];
  assign rsp_we_o     = rsp_tag_q[rsp_rd_q];
  assign proto_err_o  = proto_err_q;
  assign idle_o       = (out_cnt_q == '0) && (rsp_cnt_q == '0) && !req_q;

endmodule

// File: tb/tb_miriscv_mem_initiator.sv
module tb_miriscv_mem_initiator;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        rsp_ready_i = 1'b0;
  logic        cmd_ready_o, data_req_o, data_we_o, rsp_valid_o, rsp_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, rsp_rdata_o;
  logic        idle_o, proto_err_o, timeout_o;

  always #5 clk_i = ~clk_i;

  miriscv_mem_initiator #(
    .MAX_OUTSTANDING(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_we_o(rsp_we_o),
    .idle_o(idle_o), .proto_err_o(proto_err_o), .timeout_o(timeout_o)
  );

`ifdef MIRISCV_MEM_INIT_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs   = 0;
  logic [32:0] exp_q[$];          // {we, rdata} expected on rsp port
  typedef struct { int due; logic [31:0] data; } pend_t;
  pend_t pend_q[$];               // responder delay line
  int   cyc_n = 0;
  int   resp_lat = 1;
  logic auto_rsp = 1'b0;
  int   rvalids = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_i);
    arstn_i = 1'b0; cmd_valid_i = 1'b0; data_rvalid_i = 1'b0; rsp_ready_i = 1'b0;
    @(negedge clk_i); #1;
    check("rst_cmd_ready_low", 64'(cmd_ready_o), 64'd0);
    check("rst_idle", 64'(idle_o), 64'd1);
    @(negedge clk_i);
    arstn_i = 1'b1;
    pend_q.delete();
    exp_q.delete();
    #1;
  endtask

  // One cycle: responder observes the bus, inputs are driven, then the
  // response port is scored.
  task automatic tick(input logic cv, input logic [31:0] ca, input logic rr,
                      input logic frv, output logic fired);
    pend_t p;
    logic [32:0] e;
    @(negedge clk_i);
    if (auto_rsp && data_req_o) begin
      p.due  = cyc_n + resp_lat;
      p.data = rd_of(data_addr_o);
      pend_q.push_back(p);
    end
    cmd_valid_i = cv; cmd_we_i = 1'b0; cmd_addr_i = ca;
    cmd_wdata_i = ~ca; cmd_be_i = 4'hF; rsp_ready_i = rr;
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    if (frv) begin
      data_rvalid_i = 1'b1; data_rdata_i = 32'h55;
    end else if (auto_rsp && pend_q.size() > 0 && pend_q[0].due == cyc_n) begin
      data_rvalid_i = 1'b1; data_rdata_i = pend_q[0].data;
      void'(pend_q.pop_front());
      rvalids++;
    end
    #1;
    fired = cv && cmd_ready_o;
    if (fired) exp_q.push_back({1'b0, rd_of(ca)});
    if (rsp_valid_o && rr) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_order", 64'({rsp_we_o, rsp_rdata_o}), 64'(e));
      end
    end
    cyc_n++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic cv, cwe; logic [31:0] ca, cwd; logic [3:0] cbe;
    logic rv; logic [31:0] rd; logic rr;
    logic e_crdy, e_req, e_we; logic [3:0] e_be; logic [31:0] e_addr, e_wdata;
    logic e_rv; logic [31:0] e_rdata; logic e_rwe, e_idle, e_perr;
  } vec_t;
  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic cv, cwe, input logic [31:0] ca, cwd, input logic [3:0] cbe,
    input logic rv, input logic [31:0] rd, input logic rr,
    input logic e_crdy, e_req, e_we, input logic [3:0] e_be,
    input logic [31:0] e_addr, e_wdata, input logic e_rv,
    input logic [31:0] e_rdata, input logic e_rwe, e_idle, e_perr);
    vec_t v;
    v.cv = cv; v.cwe = cwe; v.ca = ca; v.cwd = cwd; v.cbe = cbe;
    v.rv = rv; v.rd = rd; v.rr = rr;
    v.e_crdy = e_crdy; v.e_req = e_req; v.e_we = e_we; v.e_be = e_be;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rv = e_rv;
    v.e_rdata = e_rdata; v.e_rwe = e_rwe; v.e_idle = e_idle; v.e_perr = e_perr;
    return v;
  endfunction

  initial begin
    logic f, hit;
    int   fires, first_block, rv0;
    logic rr;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic f, hit, rr;
    int   fires, first_block, rv0;

    // single read / write / back-to-back pair, bench drives rvalid directly
    vecs[0]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,1'b0,1'b1,1'b0);
    vecs[1]  = mk(1'b1,1'b0,32'h100,32'h0,4'hF, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,1'b0,1'b1,1'b0);
    vecs[2]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b0);
    vecs[3]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hDEADBEEF,1'b0,
                  1'b1,1'b0,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b0);
    vecs[4]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,
                  1'b1,1'b0,1'b0,4'hF,32'h100,32'h0, 1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0);
    vecs[5]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,1'b0,1'b1,1'b0);
    vecs[6]  = mk(1'b1,1'b1,32'h204,32'h12345678,4'h3, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0,1'b0,1'b1,1'b0);
    vecs[7]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b1,1'b1,4'h3,32'h204,32'h12345678, 1'b0,32'h0,1'b0,1'b0,1'b0);
    vecs[8]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hCAFEF00D,1'b0,
                  1'b1,1'b0,1'b1,4'h3,32'h204,32'h12345678, 1'b0,32'h0,1'b0,1'b0,1'b0);
    vecs[9]  = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b1,4'h3,32'h204,32'h12345678, 1'b1,32'h0,1'b1,1'b0,1'b0);
    vecs[10] = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,
                  1'b1,1'b0,1'b1,4'h3,32'h204,32'h12345678, 1'b1,32'h0,1'b1,1'b0,1'b0);
    vecs[11] = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b1,4'h3,32'h204,32'h12345678, 1'b0,32'h0,1'b0,1'b1,1'b0);
    vecs[12] = mk(1'b1,1'b0,32'h300,32'h0,4'hF, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b1,4'h3,32'h204,32'h12345678, 1'b0,32'h0,1'b0,1'b1,1'b0);
    vecs[13] = mk(1'b1,1'b0,32'h304,32'h0,4'hF, 1'b0,32'h0,1'b0,
                  1'b1,1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b0);
    vecs[14] = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h11111111,1'b0,
                  1'b1,1'b1,1'b0,4'hF,32'h304,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b0);
    vecs[15] = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h22222222,1'b1,
                  1'b1,1'b0,1'b0,4'hF,32'h304,32'h0, 1'b1,32'h11111111,1'b0,1'b0,1'b0);
    vecs[16] = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,
                  1'b1,1'b0,1'b0,4'hF,32'h304,32'h0, 1'b1,32'h22222222,1'b0,1'b0,1'b0);
    vecs[17] = mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,4'hF,32'h304,32'h0, 1'b0,32'h0,1'b0,1'b1,1'b0);

    do_reset();
    check("post_rst_ready", 64'(cmd_ready_o), 64'd1);
    check("post_rst_idle", 64'(idle_o), 64'd1);
    check("post_rst_req", 64'(data_req_o), 64'd0);
    check("post_rst_perr", 64'(proto_err_o), 64'd0);
    check("post_rst_timeout", 64'(timeout_o), 64'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      cmd_valid_i = vecs[i].cv; cmd_we_i = vecs[i].cwe; cmd_addr_i = vecs[i].ca;
      cmd_wdata_i = vecs[i].cwd; cmd_be_i = vecs[i].cbe;
      data_rvalid_i = vecs[i].rv; data_rdata_i = vecs[i].rd; rsp_ready_i = vecs[i].rr;
      #1;
      check($sformatf("v%0d_cmd_ready", i), 64'(cmd_ready_o), 64'(vecs[i].e_crdy));
      check($sformatf("v%0d_req", i), 64'(data_req_o), 64'(vecs[i].e_req));
      check($sformatf("v%0d_we", i), 64'(data_we_o), 64'(vecs[i].e_we));
      check($sformatf("v%0d_be", i), 64'(data_be_o), 64'(vecs[i].e_be));
      check($sformatf("v%0d_addr", i), 64'(data_addr_o), 64'(vecs[i].e_addr));
      check($sformatf("v%0d_wdata", i), 64'(data_wdata_o), 64'(vecs[i].e_wdata));
      check($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid_o), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d_rsp_rdata", i), 64'(rsp_rdata_o), 64'(vecs[i].e_rdata));
        check($sformatf("v%0d_rsp_we", i), 64'(rsp_we_o), 64'(vecs[i].e_rwe));
      end
      check($sformatf("v%0d_idle", i), 64'(idle_o), 64'(vecs[i].e_idle));
      check($sformatf("v%0d_perr", i), 64'(proto_err_o), 64'(vecs[i].e_perr));
    end

    // ---- 6 back-to-back reads, latency 5: credit limit at 4 ----
    auto_rsp = 1'b1; resp_lat = 5; rvalids = 0; fires = 0; first_block = -1;
    for (int c = 0; c < 200 && (fires < 6 || exp_q.size() > 0); c++) begin
      tick(fires < 6, 32'(32'h1000 + fires * 4), 1'b1, 1'b0, f);
      if (fires < 6 && !cmd_ready_o && first_block < 0) first_block = fires;
      if (f) begin
        if (fires >= 4) check("a_fire_after_rvalid", 64'(rvalids >= fires - 3), 64'd1);
        fires++;
      end
    end
    check("a_block_after_4", 64'(first_block), 64'd4);
    check("a_all_done", 64'((fires == 6) && (exp_q.size() == 0)), 64'd1);
    tick(1'b0, 32'h0, 1'b1, 1'b0, f);
    check("a_idle", 64'(idle_o), 64'd1);

    // ---- buffer fills with rsp_ready low ----
    resp_lat = 2; fires = 0;
    for (int c = 0; c < 40 && fires < 4; c++) begin
      tick(1'b1, 32'(32'h2000 + fires * 4), 1'b0, 1'b0, f);
      if (f) fires++;
    end
    for (int c = 0; c < 20 && (pend_q.size() > 0 || data_req_o); c++)
      tick(1'b0, 32'h0, 1'b0, 1'b0, f);
    tick(1'b0, 32'h0, 1'b0, 1'b0, f);
    check("b_full_ready", 64'(cmd_ready_o), 64'd0);
    check("b_full_valid", 64'(rsp_valid_o), 64'd1);
    check("b_full_rdata", 64'(rsp_rdata_o), 64'(rd_of(32'h2000)));
    tick(1'b0, 32'h0, 1'b0, 1'b0, f);
    check("b_stable_rdata", 64'(rsp_rdata_o), 64'(rd_of(32'h2000)));
    tick(1'b0, 32'h0, 1'b1, 1'b0, f);        // pop one
    tick(1'b0, 32'h0, 1'b0, 1'b0, f);
    check("b_credit_back", 64'(cmd_ready_o), 64'd1);
    tick(1'b1, 32'h2010, 1'b0, 1'b0, f);
    check("b_refire", 64'(f), 64'd1);
    tick(1'b0, 32'h0, 1'b0, 1'b0, f);
    check("b_refull_ready", 64'(cmd_ready_o), 64'd0);
    // pop exactly in the cycle the rvalid arrives
    rv0 = rvalids; hit = 1'b0;
    for (int c = 0; c < 10 && rvalids == rv0; c++) begin
      rr = (pend_q.size() > 0) && (pend_q[0].due == cyc_n);
      tick(1'b0, 32'h0, rr, 1'b0, f);
      if (rr && data_rvalid_i) hit = 1'b1;
    end
    check("b_same_cycle_push_pop", 64'(hit), 64'd1);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++)
      tick(1'b0, 32'h0, 1'b1, 1'b0, f);
    check("b_drained", 64'(exp_q.size()), 64'd0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, f);
    check("b_idle", 64'(idle_o), 64'd1);

    // ---- stray rvalid ----
    tick(1'b0, 32'h0, 1'b0, 1'b1, f);
    tick(1'b0, 32'h0, 1'b0, 1'b0, f);
    check("c_perr_set", 64'(proto_err_o), 64'd1);
    check("c_idle_kept", 64'(idle_o), 64'd1);
    check("c_no_rsp", 64'(rsp_valid_o), 64'd0);
    check("c_ready_kept", 64'(cmd_ready_o), 64'd1);
    tick(1'b1, 32'h3000, 1'b1, 1'b0, f);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++)
      tick(1'b0, 32'h0, 1'b1, 1'b0, f);
    check("c_read_done", 64'(exp_q.size()), 64'd0);
    check("c_perr_sticky", 64'(proto_err_o), 64'd1);

    // ---- reset with 3 requests outstanding ----
    resp_lat = 10; fires = 0;
    for (int c = 0; c < 10 && fires < 3; c++) begin
      tick(1'b1, 32'(32'h3100 + fires * 4), 1'b0, 1'b0, f);
      if (f) fires++;
    end
    check("r_pre_busy", 64'(idle_o), 64'd0);
    do_reset();
    check("r_idle", 64'(idle_o), 64'd1);
    check("r_perr_clr", 64'(proto_err_o), 64'd0);
    check("r_req_clr", 64'(data_req_o), 64'd0);
    check("r_rsp_clr", 64'(rsp_valid_o), 64'd0);

    // ---- watchdog ----
    auto_rsp = 1'b0;
    tick(1'b1, 32'h4000, 1'b1, 1'b0, f);
    check("d_fire", 64'(f), 64'd1);
    for (int k = 1; k <= 17; k++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0, f);
      if (k == 16) check("d_timeout_early", 64'(timeout_o), 64'd0);
    end
    check("d_timeout", 64'(timeout_o), 64'(EXP_TO));
    check("d_ready", 64'(cmd_ready_o), 64'(!EXP_TO));
    begin
      pend_t p;
      p.due = cyc_n; p.data = rd_of(32'h4000);
      pend_q.push_back(p);
    end
    auto_rsp = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++)
      tick(1'b0, 32'h0, 1'b1, 1'b0, f);
    check("d_drained", 64'(exp_q.size()), 64'd0);
    check("d_timeout_sticky", 64'(timeout_o), 64'(EXP_TO));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
